// File: rtl/clock_pkg.sv
// Shared constants and the alarm state encoding for the clock's audio blocks.
package clock_pkg;

   localparam int unsigned DAY_SEC         = 86400;
   localparam int          TONE_LO_BIT_DEF = 15;
   localparam int          TONE_HI_BIT_DEF = 14;

   typedef enum logic [1:0] {
      ALARM_IDLE    = 2'd0,
      ALARM_RINGING = 2'd1,
      ALARM_SNOOZED = 2'd2
   } alarm_state_e;

endpackage

// File: rtl/tone_gen.sv
// Free-running 16-bit counter; two of its bits serve as low and high audio tones.
module tone_gen
   import clock_pkg::*;
#(
   parameter int LO_BIT = TONE_LO_BIT_DEF,
   parameter int HI_BIT = TONE_HI_BIT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   output logic tone_lo,
   output logic tone_hi
);

   logic [15:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_q + 16'd1;
   end

   assign tone_lo = cnt_q[LO_BIT];
   assign tone_hi = cnt_q[HI_BIT];

endmodule

// File: rtl/chime_alarm.sv
// Interval chime with pre-beeps plus a daily alarm with snooze, ack and timeout.
// state    | meaning
// IDLE     | no alarm activity; interval chime may sound
// RINGING  | alarm sounding, high tone 1 s on / 1 s off
// SNOOZED  | silent, waiting for the snooze target second
module chime_alarm
   import clock_pkg::*;
#(
   parameter int PERIOD_SEC   = 3600,
   parameter int PRE_BEEPS    = 4,
   parameter int SNOOZE_SEC   = 300,
   parameter int MAX_SNOOZE   = 3,
   parameter int RING_MAX_SEC = 60,
   parameter int TONE_LO_BIT  = TONE_LO_BIT_DEF,
   parameter int TONE_HI_BIT  = TONE_HI_BIT_DEF,
   parameter int SEC_W        = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SEC_W-1:0] cur_sec,
   input  logic             chime_en,
   input  logic             alarm_en,
   input  logic [SEC_W-1:0] alarm_sec,
   input  logic             snooze,
   input  logic             ack,
   output logic             speaker,
   output logic [1:0]       alarm_state,
   output logic             chiming
);

   localparam int RING_W = $clog2(RING_MAX_SEC + 1);
   localparam int SNZ_W  = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

   localparam logic [SEC_W-1:0] DAY_LIM  = SEC_W'(DAY_SEC);
   localparam logic [SEC_W-1:0] PERIOD   = SEC_W'(PERIOD_SEC);
   localparam logic [SEC_W-1:0] PRE_BASE = SEC_W'(PERIOD_SEC - 2 * PRE_BEEPS);
   localparam logic [SEC_W:0]   DAY_EXT  = (SEC_W+1)'(DAY_SEC);
   localparam logic [SEC_W:0]   SNZ_EXT  = (SEC_W+1)'(SNOOZE_SEC);

   alarm_state_e      state_q, state_d;
   logic [SEC_W-1:0]  prev_sec_q;
   logic [SEC_W-1:0]  target_q, target_d;
   logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
   logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
   logic              speaker_q, speaker_d;
   logic              chiming_q, chiming_d;

   logic              tick, sec_valid;
   logic [SEC_W-1:0]  phase;
   logic              pre_slot, bnd_slot;
   logic [SEC_W:0]    snz_sum, snz_mod;
   logic              tone_lo, tone_hi;
   logic              ring_next;

   tone_gen #(
      .LO_BIT (TONE_LO_BIT),
      .HI_BIT (TONE_HI_BIT)
   ) u_tone (
      .clk     (clk),
      .rst_n   (rst_n),
      .tone_lo (tone_lo),
      .tone_hi (tone_hi)
   );

   assign tick      = (cur_sec != prev_sec_q);
   assign sec_valid = (cur_sec < DAY_LIM);

   // Pre-beep slots sit on every other second ending two seconds before the boundary.
   assign phase    = cur_sec % PERIOD;
   assign pre_slot = (phase >= PRE_BASE) && (phase[0] == PRE_BASE[0]);
   assign bnd_slot = (phase == '0);

   assign snz_sum = {1'b0, cur_sec} + SNZ_EXT;
   assign snz_mod = (snz_sum >= DAY_EXT) ? (snz_sum - DAY_EXT) : snz_sum;

   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      ring_cnt_d = ring_cnt_q;
      snz_cnt_d  = snz_cnt_q;
      if (sec_valid) begin
         case (state_q)
            ALARM_IDLE: begin
               if (tick && alarm_en && (cur_sec == alarm_sec)) begin
                  state_d    = ALARM_RINGING;
                  snz_cnt_d  = '0;
                  ring_cnt_d = '0;
               end
            end
            ALARM_RINGING: begin
               if (!alarm_en || ack) begin
                  state_d = ALARM_IDLE;
               end else if (snooze) begin
                  if (snz_cnt_q < SNZ_W'(MAX_SNOOZE)) begin
                     state_d    = ALARM_SNOOZED;
                     target_d   = SEC_W'(snz_mod);
                     snz_cnt_d  = snz_cnt_q + SNZ_W'(1);
                     ring_cnt_d = '0;
                  end else begin
                     state_d = ALARM_IDLE;
                  end
               end else if (tick) begin
                  ring_cnt_d = ring_cnt_q + RING_W'(1);
                  if (ring_cnt_d >= RING_W'(RING_MAX_SEC)) state_d = ALARM_IDLE;
               end
            end
            ALARM_SNOOZED: begin
               if (!alarm_en || ack) begin
                  state_d = ALARM_IDLE;
               end else if (tick && (cur_sec == target_q)) begin
                  state_d = ALARM_RINGING;
               end
            end
            default: state_d = ALARM_IDLE;
         endcase
      end
   end

   // Outputs follow the next state so a trigger silences the chime on the same edge.
   always_comb begin
      ring_next = (state_d == ALARM_RINGING);
      chiming_d = chime_en && sec_valid && (pre_slot || bnd_slot) && !ring_next;
      speaker_d = 1'b0;
      if (ring_next)      speaker_d = tone_hi & ~cur_sec[0];
      else if (chiming_d) speaker_d = bnd_slot ? tone_hi : tone_lo;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ALARM_IDLE;
         prev_sec_q <= '0;
         target_q   <= '0;
         ring_cnt_q <= '0;
         snz_cnt_q  <= '0;
         speaker_q  <= 1'b0;
         chiming_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_sec_q <= cur_sec;
         target_q   <= target_d;
         ring_cnt_q <= ring_cnt_d;
         snz_cnt_q  <= snz_cnt_d;
         speaker_q  <= speaker_d;
         chiming_q  <= chiming_d;
      end
   end

   assign speaker     = speaker_q;
   assign chiming     = chiming_q;
   assign alarm_state = state_q;

endmodule

// File: tb/tb_chime_alarm.sv
// Directed and randomized checks of chime_alarm against a seconds-level reference model.
module tb_chime_alarm;

   localparam int PERIOD = 3600;
   localparam int PRE    = 4;
   localparam int SNZ    = 300;
   localparam int MAXS   = 3;
   localparam int RMAX   = 60;
   localparam int LO_B   = 3;
   localparam int HI_B   = 2;
   localparam int SW     = 17;
   localparam int DAY    = 86400;

   localparam int M_IDLE = 0;
   localparam int M_RING = 1;
   localparam int M_SNZ  = 2;

   logic          clk;
   logic          rst_n;
   logic [SW-1:0] cur_sec;
   logic          chime_en;
   logic          alarm_en;
   logic [SW-1:0] alarm_sec;
   logic          snooze;
   logic          ack;
   logic          speaker;
   logic [1:0]    alarm_state;
   logic          chiming;

   int checks = 0;
   int errors = 0;

   int m_state, m_prev, m_snz, m_ring, m_target, m_tone;
   int e_spk, e_chm, e_state;

   chime_alarm #(
      .PERIOD_SEC   (PERIOD),
      .PRE_BEEPS    (PRE),
      .SNOOZE_SEC   (SNZ),
      .MAX_SNOOZE   (MAXS),
      .RING_MAX_SEC (RMAX),
      .TONE_LO_BIT  (LO_B),
      .TONE_HI_BIT  (HI_B),
      .SEC_W        (SW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cur_sec     (cur_sec),
      .chime_en    (chime_en),
      .alarm_en    (alarm_en),
      .alarm_sec   (alarm_sec),
      .snooze      (snooze),
      .ack         (ack),
      .speaker     (speaker),
      .alarm_state (alarm_state),
      .chiming     (chiming)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h (cur_sec %0d)", tag, obs, exp, cur_sec);
      end
   endtask

   task automatic model_reset();
      m_state = M_IDLE; m_prev = 0; m_snz = 0; m_ring = 0; m_target = 0; m_tone = 0;
   endtask

   // Expected outputs after the coming edge, from the rules stated in seconds.
   task automatic model_edge();
      int  s, ns, ph;
      bit  tick, valid, lo_slot, hi_slot, t_lo, t_hi;
      s     = int'(cur_sec);
      tick  = (s != m_prev);
      valid = (s < DAY);
      ns    = m_state;
      if (valid) begin
         if (m_state == M_IDLE) begin
            if (tick && alarm_en && s == int'(alarm_sec)) begin
               ns = M_RING; m_snz = 0; m_ring = 0;
            end
         end else if (m_state == M_RING) begin
            if (!alarm_en || ack) ns = M_IDLE;
            else if (snooze) begin
               if (m_snz < MAXS) begin
                  ns = M_SNZ; m_target = (s + SNZ) % DAY; m_snz++; m_ring = 0;
               end else ns = M_IDLE;
            end else if (tick) begin
               m_ring++;
               if (m_ring == RMAX) ns = M_IDLE;
            end
         end else begin
            if (!alarm_en || ack) ns = M_IDLE;
            else if (tick && s == m_target) ns = M_RING;
         end
      end
      ph = s % PERIOD;
      lo_slot = 0;
      for (int k = 0; k < PRE; k++) if (ph == PERIOD - 2 * PRE + 2 * k) lo_slot = 1;
      hi_slot = (ph == 0);
      t_lo = ((m_tone >> LO_B) & 1) != 0;
      t_hi = ((m_tone >> HI_B) & 1) != 0;
      e_chm = (chime_en && valid && (lo_slot || hi_slot) && ns != M_RING) ? 1 : 0;
      if (ns == M_RING)    e_spk = (t_hi && (s % 2 == 0)) ? 1 : 0;
      else if (e_chm != 0) e_spk = hi_slot ? int'(t_hi) : int'(t_lo);
      else                 e_spk = 0;
      e_state = ns;
      m_state = ns;
      m_prev  = s;
      m_tone  = (m_tone + 1) % 65536;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("speaker", 32'(speaker), 32'(e_spk));
      chk("chiming", 32'(chiming), 32'(e_chm));
      chk("alarm_state", 32'(alarm_state), 32'(e_state));
   endtask

   task automatic sec(input int s);
      cur_sec = SW'(s);
      repeat ($urandom_range(1, 3)) step();
   endtask

   task automatic pulse(input bit do_snz, input bit do_ack);
      snooze = do_snz; ack = do_ack;
      step();
      snooze = 1'b0; ack = 1'b0;
   endtask

   initial begin
      int pick, s;
      rst_n = 1'b0; cur_sec = '0; chime_en = 1'b0; alarm_en = 1'b0;
      alarm_sec = '0; snooze = 1'b0; ack = 1'b0;
      model_reset();
      #3;
      chk("rst_speaker", 32'(speaker), 32'd0);
      chk("rst_chiming", 32'(chiming), 32'd0);
      chk("rst_state", 32'(alarm_state), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // interval chime around the hour boundary
      chime_en = 1'b1;
      for (int t = 3591; t <= 3601; t++) begin
         sec(t);
         if (t == 3592 || t == 3598 || t == 3600) chk("chime_slot", 32'(chiming), 32'd1);
         if (t == 3593 || t == 3599 || t == 3601) chk("chime_gap", 32'(chiming), 32'd0);
      end

      // alarm rings, then times out after RMAX ticks
      chime_en = 1'($urandom_range(0, 1));
      alarm_sec = SW'(25200); alarm_en = 1'b1;
      sec(25199);
      sec(25200);
      chk("ring_start", 32'(alarm_state), 32'd1);
      for (int t = 25201; t <= 25262; t++) begin
         sec(t);
         if (t == 25259) chk("ring_before_timeout", 32'(alarm_state), 32'd1);
         if (t == 25260) chk("ring_timeout", 32'(alarm_state), 32'd0);
      end

      // snooze three times, fourth snooze acts as ack
      sec(25199);
      sec(25200);
      for (int t = 25201; t <= 25210; t++) sec(t);
      pulse(1'b1, 1'b0);
      chk("snoozed", 32'(alarm_state), 32'd2);
      for (int n = 0; n < 3; n++) begin
         s = 25510 + 300 * n;
         sec(s - 1);
         chk("still_snoozed", 32'(alarm_state), 32'd2);
         sec(s);
         chk("snooze_ring", 32'(alarm_state), 32'd1);
         pulse(1'b1, 1'b0);
      end
      chk("fourth_snooze_idle", 32'(alarm_state), 32'd0);

      // snooze target wraps past midnight
      alarm_sec = SW'(86300);
      sec(86299);
      sec(86300);
      pulse(1'b1, 1'b0);
      sec(86399);
      sec(0);
      sec(199);
      chk("wrap_wait", 32'(alarm_state), 32'd2);
      sec(200);
      chk("wrap_ring", 32'(alarm_state), 32'd1);
      pulse(1'b0, 1'b1);

      // out-of-range seconds neither trigger nor chime
      alarm_sec = SW'(86450); chime_en = 1'b1;
      sec(86449);
      sec(86450);
      chk("oor_no_alarm", 32'(alarm_state), 32'd0);
      sec(86400);
      chk("oor_no_chime", 32'(chiming), 32'd0);

      // ack beats snooze, no retrigger while second is unchanged
      alarm_sec = SW'(1000);
      sec(999);
      sec(1000);
      pulse(1'b1, 1'b1);
      chk("ack_wins", 32'(alarm_state), 32'd0);
      repeat (4) step();
      chk("no_retrigger", 32'(alarm_state), 32'd0);

      // alarm overlapping the boundary chime, then reset mid-ring
      alarm_sec = SW'(3600); chime_en = 1'b1;
      sec(3598);
      sec(3599);
      sec(3600);
      chk("ring_over_chime", 32'(chiming), 32'd0);
      sec(3601);
      sec(3602);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_speaker", 32'(speaker), 32'd0);
      chk("async_rst_state", 32'(alarm_state), 32'd0);
      alarm_en = 1'b0;
      model_reset();
      #2;
      rst_n = 1'b1;
      step();

      // randomized seconds, pulses and enables
      for (int it = 0; it < 250; it++) begin
         if ($urandom_range(0, 9) == 0) alarm_en = ~alarm_en;
         if ($urandom_range(0, 7) == 0) chime_en = ~chime_en;
         if ($urandom_range(0, 19) == 0) alarm_sec = SW'($urandom_range(0, DAY - 1));
         pick = $urandom_range(0, 5);
         case (pick)
            0: s = $urandom_range(0, 131071);
            1: s = int'(alarm_sec);
            2: s = m_target;
            3: s = PERIOD * $urandom_range(0, 23) + $urandom_range(0, PERIOD - 1);
            4: s = (PERIOD * $urandom_range(1, 24) - $urandom_range(0, 10)) % DAY;
            default: s = (int'(cur_sec) + 1) % DAY;
         endcase
         sec(s);
         if ($urandom_range(0, 5) == 0)
            pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/chime_alarm.md
# chime_alarm

Second-driven audio event generator for the digital clock. It extends the fixed hourly pip logic into a parametrised interval chime with a configurable pre-beep count, and adds a daily alarm with snooze, acknowledge and auto-timeout. It sits between the seconds-of-day timekeeper and the speaker pin, and drives the status LEDs.

## Interface
- PERIOD_SEC, 3600: chime interval in seconds; must divide DAY_SEC.
- PRE_BEEPS, 4: low-tone pips before the interval boundary; 0..PERIOD_SEC/2-1.
- SNOOZE_SEC, 300: snooze delay in seconds.
- MAX_SNOOZE, 3: snoozes allowed per alarm event; further snooze requests are treated as ack.
- RING_MAX_SEC, 60: an unattended alarm stops after this many seconds.
- TONE_LO_BIT, 15 / TONE_HI_BIT, 14: tone-counter bits used for the low and high tones.
- SEC_W, 17: width of the seconds-of-day inputs.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cur_sec  in  SEC_W  current seconds of day, 0..86399.
- chime_en  in  1  enables the interval chime.
- alarm_en  in  1  enables the alarm; deassertion cancels any ring or snooze.
- alarm_sec  in  SEC_W  alarm time in seconds of day.
- snooze  in  1  single-cycle snooze request.
- ack  in  1  single-cycle alarm acknowledge.
- speaker  out  1  square-wave audio output, registered.
- alarm_state  out  2  0 IDLE, 1 RINGING, 2 SNOOZED.
- chiming  out  1  high while a chime pip is sounding.

## Operation
- Second tick: tick = (cur_sec != prev_sec). prev_sec is registered. All second-based decisions are taken on tick cycles only.
- Chime phase: ph = cur_sec % PERIOD_SEC.
  - Pre-beep slots: ph = PERIOD_SEC − 2·PRE_BEEPS + 2k, for k = 0..PRE_BEEPS−1. These use the low tone.
  - Boundary slot: ph = 0. This uses the high tone.
  - Gaps between slots are silent.
  - chiming is asserted only when chime_en is high and the alarm is not RINGING.
- Alarm FSM:
  - IDLE → RINGING on a tick when alarm_en is high and cur_sec == alarm_sec. This clears snooze_cnt and ring_cnt.
  - RINGING → IDLE on ack, when alarm_en is low, or when ring_cnt reaches RING_MAX_SEC.
  - RINGING → SNOOZED on snooze when snooze_cnt < MAX_SNOOZE. This sets target = (cur_sec + SNOOZE_SEC) mod 86400, increments snooze_cnt and clears ring_cnt.
  - RINGING → IDLE on snooze when snooze_cnt == MAX_SNOOZE.
  - SNOOZED → RINGING on a tick with cur_sec == target.
  - SNOOZED → IDLE on ack or when alarm_en is low.
  - ring_cnt increments on each tick while RINGING.
- Speaker priority:
  - RINGING: high tone gated by cur_sec[0] == 0, giving a 1 s on / 1 s off pattern.
  - Else chiming: the slot's tone.
  - Else 0.
- Tone source: a free-running 16-bit counter inside tone_gen.

## Timing
- Reset values: speaker 0, alarm_state IDLE, chiming 0, prev_sec 0, snooze_cnt 0, ring_cnt 0, target 0, tone counter 0.
- Latency from a cur_sec change to speaker, chiming or alarm_state: exactly 1 clk.
- snooze and ack act in the cycle they are sampled high; the next-state register updates on the following edge.
- ack and snooze in the same cycle: ack wins.
- snooze or ack while IDLE: ignored.
- Alarm trigger and snooze expiry in the same tick: the FSM is already RINGING and stays there.
- After an ack, cur_sec still equal to alarm_sec does not retrigger, because there is no new tick.
- Snooze target wrap: 86300 + 300 gives target 200.
- cur_sec ≥ 86400: no alarm trigger, no chime, and the FSM holds its state.
- Reset mid-ring: speaker goes to 0 immediately (asynchronous) and the FSM returns to IDLE.
- Arithmetic: (cur_sec + SNOOZE_SEC) is computed at SEC_W+1 bits before the modulo.

## Structure
- Shared package clock_pkg holds:
  - DAY_SEC = 86400.
  - The alarm state encoding (IDLE/RINGING/SNOOZED).
  - Tone-bit defaults.
- One sub-module, tone_gen: free-running counter with outputs tone_lo and tone_hi. It is reusable by the key-click block.
- Everything else (tick detection, phase decode, FSM, counters, output mux) lives in chime_alarm.

## Test plan
1. Chime with defaults, chime_en=1, cur_sec stepped 3591→3601 → low tone at 3592/3594/3596/3598, high tone at 3600, silence elsewhere, chiming toggling accordingly.
2. alarm_sec=25200, alarm_en=1, cur_sec reaches 25200 → RINGING one clk later. Speaker toggles only on even seconds. IDLE reached after 60 ticks with no input.
3. Ringing, snooze pulse at 25210 → SNOOZED, target 25510. At 25510 → RINGING. After the third snooze, a fourth snooze → IDLE.
4. alarm_sec=86300, snooze at 86300 → target 200 after midnight wrap. Ring at cur_sec=200.
5. Ringing with ack and snooze in the same cycle → IDLE. Holding cur_sec=alarm_sec afterwards → no retrigger.
6. Ring overlapping chime slot 3600 with chime_en=1 → alarm pattern only, chiming=0. rst_n low mid-ring → speaker 0 and alarm_state 0 without waiting for a clock edge.
